// File: rtl/pipe_adder.sv
// Pipelined N-bit add/subtract unit. Each of STAGES stages adds one W=N/STAGES chunk, and the carry is registered between stages.
// Optional status flags {ovf, neg, zero} are built only when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic [2:0]   flags
);
   localparam int W = N / STAGES;
   localparam int L = STAGES - 1;

   if (N % STAGES != 0) begin : g_bad_cfg
      $error("pipe_adder: N (%0d) must be a multiple of STAGES (%0d)", N, STAGES);
   end

   logic         w_en;
   logic [N-1:0] w_b_eff;

   // Global stall. in_ready follows out_ready combinationally, so upstream must not feed in_ready back into in_valid.
   assign w_en     = out_ready | ~out_valid;
   assign in_ready = w_en;
   assign w_b_eff  = sub ? ~b : b;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [N-k*W-1:0]   w_src_a;
      logic [N-k*W-1:0]   w_src_b;
      logic               w_cin;
      logic               w_vin;
      logic [W-1:0]       w_a;
      logic [W-1:0]       w_b;
      logic [W:0]         w_add;
      logic [(k+1)*W-1:0] w_sum_next;
      logic               r_v;
      logic               r_c;
      logic [(k+1)*W-1:0] r_sum;

      if (k == 0) begin : g_head
         assign w_src_a    = a;
         assign w_src_b    = w_b_eff;
         assign w_cin      = sub ? 1'b1 : cin;
         assign w_vin      = in_valid;
         assign w_sum_next = w_add[W-1:0];
      end else begin : g_body
         // Unused operand chunks shift down the skewed line, and finished result chunks accumulate below the new chunk.
         assign w_src_a    = g_stage[k-1].g_ops.r_a;
         assign w_src_b    = g_stage[k-1].g_ops.r_b;
         assign w_cin      = g_stage[k-1].r_c;
         assign w_vin      = g_stage[k-1].r_v;
         assign w_sum_next = {w_add[W-1:0], g_stage[k-1].r_sum};
      end

      assign w_a   = w_src_a[W-1:0];
      assign w_b   = w_src_b[W-1:0];
      assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};

      // NOTE: non-blocking assignments make each stage sample its predecessor's pre-edge value.
      // The data registers are reset as well, so s and cout read 0 straight out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_sum <= '0;
         end else if (w_en) begin
            r_v   <= w_vin;
            r_c   <= w_add[W];
            r_sum <= w_sum_next;
         end
      end

      if (k < L) begin : g_ops
         logic [N-(k+1)*W-1:0] r_a;
         logic [N-(k+1)*W-1:0] r_b;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_en) begin
               r_a <= w_src_a[N-k*W-1:W];
               r_b <= w_src_b[N-k*W-1:W];
            end
         end
      end
   end

   assign out_valid = g_stage[L].r_v;
   assign cout      = g_stage[L].r_c;
   assign s         = g_stage[L].r_sum;

`ifdef PIPE_ADDER_FLAGS_EN
   logic       w_ovf;
   logic [2:0] r_flags;

   // Signed overflow: both addend signs (b already inverted for subtract) agree, but the result sign differs.
   assign w_ovf = (g_stage[L].w_a[W-1] == g_stage[L].w_b[W-1]) &&
                  (g_stage[L].w_sum_next[N-1] != g_stage[L].w_a[W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags <= 3'b000;
      end else if (w_en) begin
         r_flags <= {w_ovf, g_stage[L].w_sum_next[N-1], g_stage[L].w_sum_next == '0};
      end
   end

   assign flags = r_flags;
`else
   assign flags = 3'b000;
`endif

endmodule
